// File: rtl/div_pkg.sv
// Shared encodings and helpers for the RV64M iterative divider.
// Op codes match funct3[1:0] of DIV/DIVU/REM/REMU.
package div_pkg;

    localparam int XLEN_DEFAULT = 64;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t DONE = 2'd2;

    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic is_rem_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on magnitudes.
// Invariant: rem_in < divisor, so the shifted remainder fits in XLEN+1 bits.
module div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted_s;
    logic [XLEN:0] trial_s;

    // Shift {rem,quo} left, trial-subtract, keep difference if non-negative
    always_comb begin
        shifted_s = {rem_in, quo_in[XLEN-1]};
        trial_s   = shifted_s - {1'b0, divisor};
        if (trial_s[XLEN]) begin
            rem_out = shifted_s[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end else begin
            rem_out = trial_s[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle RV64M divide/remainder unit with registered write-back outputs.
// Special cases take a single CALC cycle so their latency is one edge after accept.
module iterative_divider
    import div_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int ITER = XLEN / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER);

    state_t          state_q,   state_d;
    logic [CW-1:0]   count_q,   count_d;
    logic [XLEN-1:0] rem_q,     rem_d;
    logic [XLEN-1:0] quo_q,     quo_d;
    logic [XLEN-1:0] dvs_q,     dvs_d;
    logic [1:0]      op_q,      op_d;
    logic [4:0]      rd_q,      rd_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            special_q, special_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;
    logic [XLEN-1:0] result_q,  result_d;
    logic [4:0]      rd_out_q,  rd_out_d;

    logic [XLEN-1:0] rem_chain_s [BITS_PER_CYCLE+1];
    logic [XLEN-1:0] quo_chain_s [BITS_PER_CYCLE+1];

    logic            sign_a_s, sign_b_s, div_zero_s, ovf_s;
    logic [XLEN-1:0] abs_a_s, abs_b_s, special_val_s, final_s;

    assign rem_chain_s[0] = rem_q;
    assign quo_chain_s[0] = quo_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        div_step #(.XLEN(XLEN)) u_step (
            .rem_in  (rem_chain_s[i]),
            .quo_in  (quo_chain_s[i]),
            .divisor (dvs_q),
            .rem_out (rem_chain_s[i+1]),
            .quo_out (quo_chain_s[i+1])
        );
    end

    // Operand conditioning: magnitudes, sign flags and RISC-V special results
    always_comb begin
        sign_a_s   = is_signed_op(op) & dividend[XLEN-1];
        sign_b_s   = is_signed_op(op) & divisor[XLEN-1];
        abs_a_s    = sign_a_s ? ({XLEN{1'b0}} - dividend) : dividend;
        abs_b_s    = sign_b_s ? ({XLEN{1'b0}} - divisor) : divisor;
        div_zero_s = (divisor == {XLEN{1'b0}});
        ovf_s      = is_signed_op(op)
                     && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                     && (divisor == {XLEN{1'b1}});
        if (div_zero_s) begin
            special_val_s = is_rem_op(op) ? dividend : {XLEN{1'b1}};
        end else begin
            special_val_s = is_rem_op(op) ? {XLEN{1'b0}} : dividend;
        end
    end

    // Sign fix-up applied on the last CALC edge so result is registered with done
    always_comb begin
        if (special_q) begin
            final_s = quo_q;
        end else if (is_rem_op(op_q)) begin
            final_s = neg_rem_q ? ({XLEN{1'b0}} - rem_chain_s[BITS_PER_CYCLE])
                                : rem_chain_s[BITS_PER_CYCLE];
        end else begin
            final_s = neg_quo_q ? ({XLEN{1'b0}} - quo_chain_s[BITS_PER_CYCLE])
                                : quo_chain_s[BITS_PER_CYCLE];
        end
    end

    // Next-state logic; abort overrides everything and leaves outputs held
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        op_d      = op_q;
        rd_d      = rd_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        special_d = special_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d   = CALC;
                        busy_d    = 1'b1;
                        op_d      = op;
                        rd_d      = rd_in;
                        neg_quo_d = sign_a_s ^ sign_b_s;
                        neg_rem_d = sign_a_s;
                        dvs_d     = abs_b_s;
                        rem_d     = {XLEN{1'b0}};
                        if (div_zero_s || ovf_s) begin
                            special_d = 1'b1;
                            quo_d     = special_val_s;
                            count_d   = CW'(ITER - 1);
                        end else begin
                            special_d = 1'b0;
                            quo_d     = abs_a_s;
                            count_d   = {CW{1'b0}};
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    rem_d   = rem_chain_s[BITS_PER_CYCLE];
                    quo_d   = quo_chain_s[BITS_PER_CYCLE];
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(ITER - 1)) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = final_s;
                        rd_out_d = rd_q;
                    end else begin
                        busy_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= {CW{1'b0}};
            rem_q     <= {XLEN{1'b0}};
            quo_q     <= {XLEN{1'b0}};
            dvs_q     <= {XLEN{1'b0}};
            op_q      <= 2'b00;
            rd_q      <= 5'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            special_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= {XLEN{1'b0}};
            rd_out_q  <= 5'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            special_q <= special_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: stimulus pushes expected results,
// a negedge monitor pops and compares result, rd_out and done latency.
module tb_iterative_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [63:0] dividend = 64'd0;
    logic [63:0] divisor = 64'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy, done;
    logic [63:0] result;
    logic [4:0]  rd_out;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    iterative_divider #(.XLEN(64), .BITS_PER_CYCLE(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .rd_in    (rd_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected entry
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 rd_out=%0d expected no done", rd_out);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("rd_out", 64'(rd_out), 64'(e.rd));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("busy_in_done", 64'(busy), 64'd0);
            end
        end
    end

    // Called at a negedge; start is sampled by the following posedge
    task automatic issue(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input logic push, input logic [63:0] er,
                         input int lat);
        exp_t e;
        int   w = 0;
        while (busy && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: got busy=1 expected busy=0");
        end
        op = o; dividend = a; divisor = b; rd_in = rd; start = 1'b1;
        if (push) begin
            e.res = er; e.rd = rd; e.cyc = cyc + 1 + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        vecs[0]  = '{2'b01, 64'd100, 64'd7, 5'd5, 64'd14, 64};
        vecs[1]  = '{2'b11, 64'd100, 64'd7, 5'd6, 64'd2, 64};
        vecs[2]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64};
        vecs[3]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64};
        vecs[4]  = '{2'b10, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd9, 64'd1, 64};
        vecs[5]  = '{2'b01, 64'd5, 64'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[6]  = '{2'b10, 64'd5, 64'd0, 5'd11, 64'd5, 1};
        vecs[7]  = '{2'b00, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12,
                     64'h8000_0000_0000_0000, 1};
        vecs[8]  = '{2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 64'd0, 1};
        vecs[9]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd14, 64'h5555_5555_5555_5555, 64};
        vecs[10] = '{2'b00, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd0, 64'hFFFF_FFFF_FFFF_FFF2, 64};
        vecs[11] = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 5'd31, 64'hF, 64};

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_rd_out", 64'(rd_out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b1, vecs[i].exp, vecs[i].lat);
            drain();
        end

        // Start while busy is ignored; then back-to-back issue in the DONE cycle
        issue(2'b01, 64'd1000, 64'd10, 5'd9, 1'b1, 64'd100, 64);
        repeat (9) @(negedge clk);
        op = 2'b01; dividend = 64'd50; divisor = 64'd5; rd_in = 5'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!done && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("done_reached", 64'(done), 64'd1);
        issue(2'b11, 64'd1000, 64'd7, 5'd11, 1'b1, 64'd6, 64);
        drain();

        // Abort mid-CALC: no done, previous result held
        issue(2'b01, 64'd77, 64'd7, 5'd3, 1'b0, 64'd0, 0);
        repeat (19) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        repeat (70) @(negedge clk);
        check("abort_result_held", result, 64'd6);
        check("abort_rd_held", 64'(rd_out), 64'd11);

        // Asynchronous reset mid-CALC, then a fresh operation
        issue(2'b01, 64'd99, 64'd9, 5'd4, 1'b0, 64'd0, 0);
        repeat (29) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_result", result, 64'd0);
        check("arst_rd_out", 64'(rd_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(2'b00, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd12, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64);
        drain();
        repeat (70) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
